multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle version of the CPU. Sequences the shared
//  datapath (one ALU, one unified memory port, PC/IR/ALUOut registers) through
//  FETCH/DECODE/EXEC/MEM/WB steps. Waits on a memory ready handshake and traps
//  on illegal opcodes. Sits beside the datapath top level and replaces the
//  single-cycle decoder.
// PARAMETERS
//  TIMEOUT   255  max cycles to wait for mem_ready_i before trapping (>=1)
//  CNT_W     8    width of the internal wait counter (2**CNT_W > TIMEOUT)
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   asynchronous reset, active-low
//  instr_op_i     in   6   IR[31:26]; valid from DECODE onward
//  instr_funct_i  in   6   IR[5:0]
//  zero_i         in   1   ALU zero flag (combinational, current cycle)
//  mem_ready_i    in   1   memory has completed the current read/write
//  pc_write_o     out  1   load PC this cycle
//  ir_write_o     out  1   load IR from memory data
//  iord_o         out  1   mem address: 0=PC, 1=ALUOut
//  mem_read_o     out  1   memory read request
//  mem_write_o    out  1   memory write request
//  reg_write_o    out  1   register file write enable
//  reg_dst_o      out  2   00=rt, 01=rd, 10=$31
//  mem_to_reg_o   out  2   00=ALUOut, 01=MDR, 10=PC
//  alu_src_a_o    out  1   0=PC, 1=RS
//  alu_src_b_o    out  2   00=RT, 01=const 4, 10=sext imm, 11=sext imm<<2
//  alu_op_o       out  3   000=add, 001=sub, 010=R-type funct, 011=or
//  pc_src_o       out  2   00=ALU result, 01=ALUOut, 10=jump target, 11=RS
//  illegal_o      out  1   sticky trap flag (bad opcode or mem timeout)
//  state_o        out  4   current state encoding (debug)
//  retired_o      out  32  retired-instruction count, wraps 2^32-1 -> 0
// BEHAVIOUR
//  - Reset (rst_i=0): state=FETCH, wait counter=0, illegal_o=0, retired_o=0.
//    All strobes and select outputs are forced to 0 while rst_i is low.
//  - Outputs are Moore (decoded from state, plus op/funct/zero).
//  - Unlisted outputs are 0 in every state.
//  - State encodings: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5
//    EXEC=6 ALUWB=7 BRANCH=8 JUMP=9 TRAP=10.
//  - FETCH: mem_read=1, iord=0, srcA=0, srcB=01, aluop=add.
//    On mem_ready_i: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
//    Otherwise stay and hold.
//  - DECODE: srcA=0, srcB=11, add (branch target into ALUOut). Dispatch:
//    op 23/2B -> MEMADR; 00 with funct 08 (jr) -> JUMP; 00/08/0D -> EXEC;
//    04/05 -> BRANCH; 02/03 -> JUMP; any other op -> TRAP.
//  - MEMADR: srcA=1, srcB=10, add. Next state MEMRD (lw) or MEMWR (sw).
//  - MEMRD: iord=1, mem_read=1. Wait for ready, then MEMWB.
//  - MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01, then FETCH.
//  - MEMWR: iord=1, mem_write=1. Wait for ready, then FETCH.
//  - EXEC: srcA=1. R-type: srcB=00, aluop=010. addi: srcB=10, add.
//    ori: srcB=10, or. Next state ALUWB.
//  - ALUWB: reg_write=1, mem_to_reg=00, reg_dst=01 (R) or 00 (I), then FETCH.
//  - BRANCH: srcA=1, srcB=00, sub, pc_src=01.
//    pc_write = zero_i (beq) or !zero_i (bne). Then FETCH.
//  - JUMP: pc_write=1. pc_src=11 for jr, 10 otherwise.
//    jal also drives reg_write=1, reg_dst=10, mem_to_reg=10 (PC already +4).
//    Then FETCH.
//  - Wait counter: cleared on entry to FETCH/MEMRD/MEMWR, +1 per cycle without
//    ready. Reaching TIMEOUT without ready -> TRAP.
//  - Request strobes stay high until ready, or until the timeout fires.
//  - TRAP: illegal_o=1, no strobes. TRAP is absorbing until reset.
//  - retired_o increments by 1 on each transition into FETCH from MEMWB,
//    MEMWR, ALUWB, BRANCH or JUMP.
//  - Async reset mid-instruction abandons it: no partial writes, no retire.
//  - CPI: lw 5, sw 4, R/I 4, branch 3, jump 3 (+ memory wait cycles).
// TESTING
//  - add (op 00, funct 20), ready tied 1 -> FETCH,DECODE,EXEC,ALUWB,FETCH.
//    reg_write=1 with reg_dst=01 only in ALUWB; retired_o=1.
//  - lw with ready low 3 cycles in MEMRD -> mem_read/iord held 4 cycles,
//    then MEMWB with mem_to_reg=01; total 8 cycles.
//  - beq with zero_i=0 -> pc_write=0 in BRANCH; with zero_i=1 -> pc_write=1,
//    pc_src=01; 3 cycles each.
//  - jal -> JUMP with pc_write=1, pc_src=10, reg_dst=10, mem_to_reg=10.
//    jr (00/08) -> pc_src=11, reg_write=0.
//  - op 3F -> TRAP, illegal_o=1 held 100 cycles. TIMEOUT=4 with ready stuck
//    low in FETCH -> TRAP after 4 cycles. rst_i low -> FETCH, illegal_o=0.
//  - Assert rst_i low mid-MEMWR -> mem_write_o drops in the same cycle
//    (async); retired_o=0 after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: sequences the shared datapath through
// fetch/decode/execute/memory/writeback with ready handshake and traps.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  instr_op_i,
  input  logic [5:0]  instr_funct_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        iord_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic [1:0]  reg_dst_o,
  output logic [1:0]  mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic [1:0]  pc_src_o,
  output logic        illegal_o,
  output logic [3:0]  state_o,
  output logic [31:0] retired_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    TRAP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR   = 6'h08;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            stateNext;
  logic [CNT_W-1:0]  waitCnt;
  logic [31:0]       retired;
  logic              illegalQ;

  logic              pcWrite;
  logic              irWrite;
  logic              iord;
  logic              memRead;
  logic              memWrite;
  logic              regWrite;
  logic [1:0]        regDst;
  logic [1:0]        memToReg;
  logic              aluSrcA;
  logic [1:0]        aluSrcB;
  logic [2:0]        aluOp;
  logic [1:0]        pcSrc;

  logic isR;
  logic opJr;
  logic opAlu;
  logic opMem;
  logic opBr;
  logic opJmp;
  logic waitState;
  logic timeoutHit;
  logic retireEv;

  // Dispatch classes are mutually exclusive so the decoder can be unique.
  assign isR   = instr_op_i == OP_R;
  assign opJr  = isR && instr_funct_i == FN_JR;
  assign opAlu = (isR && instr_funct_i != FN_JR)
              || instr_op_i == OP_ADDI
              || instr_op_i == OP_ORI;
  assign opMem = instr_op_i == OP_LW || instr_op_i == OP_SW;
  assign opBr  = instr_op_i == OP_BEQ || instr_op_i == OP_BNE;
  assign opJmp = instr_op_i == OP_J || instr_op_i == OP_JAL;

  assign waitState = state == FETCH
                  || state == MEMRD
                  || state == MEMWR;

  assign timeoutHit = waitState && !mem_ready_i
                   && waitCnt == CNT_LAST;

  assign retireEv = stateNext == FETCH
                 && (state == MEMWB || state == MEMWR
                  || state == ALUWB || state == BRANCH
                  || state == JUMP);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= FETCH;
    end else begin
      state <= stateNext;
    end
  end

  // Any state change clears the counter; it only matters in wait states.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      waitCnt <= '0;
    end else if (stateNext != state) begin
      waitCnt <= '0;
    end else if (waitState && !mem_ready_i) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      retired <= '0;
    end else if (retireEv) begin
      retired <= retired + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      illegalQ <= 1'b0;
    end else if (stateNext == TRAP) begin
      illegalQ <= 1'b1;
    end
  end

  always_comb begin
    stateNext = state;
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    iord      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    regDst    = 2'b00;
    memToReg  = 2'b00;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = 3'b000;
    pcSrc     = 2'b00;
    unique case (state)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        if (mem_ready_i) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          stateNext = DECODE;
        end else if (timeoutHit) begin
          stateNext = TRAP;
        end
      end
      DECODE: begin
        aluSrcB = 2'b11;
        unique case (1'b1)
          opMem:   stateNext = MEMADR;
          opJr:    stateNext = JUMP;
          opAlu:   stateNext = EXEC;
          opBr:    stateNext = BRANCH;
          opJmp:   stateNext = JUMP;
          default: stateNext = TRAP;
        endcase
      end
      MEMADR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        stateNext = (instr_op_i == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        memRead = 1'b1;
        if (mem_ready_i) begin
          stateNext = MEMWB;
        end else if (timeoutHit) begin
          stateNext = TRAP;
        end
      end
      MEMWB: begin
        regWrite  = 1'b1;
        memToReg  = 2'b01;
        stateNext = FETCH;
      end
      MEMWR: begin
        iord     = 1'b1;
        memWrite = 1'b1;
        if (mem_ready_i) begin
          stateNext = FETCH;
        end else if (timeoutHit) begin
          stateNext = TRAP;
        end
      end
      EXEC: begin
        aluSrcA = 1'b1;
        if (isR) begin
          aluOp = 3'b010;
        end else begin
          aluSrcB = 2'b10;
          aluOp   = (instr_op_i == OP_ORI) ? 3'b011 : 3'b000;
        end
        stateNext = ALUWB;
      end
      ALUWB: begin
        regWrite  = 1'b1;
        regDst    = isR ? 2'b01 : 2'b00;
        stateNext = FETCH;
      end
      BRANCH: begin
        aluSrcA   = 1'b1;
        aluOp     = 3'b001;
        pcSrc     = 2'b01;
        pcWrite   = (instr_op_i == OP_BEQ) ? zero_i : !zero_i;
        stateNext = FETCH;
      end
      JUMP: begin
        pcWrite = 1'b1;
        if (isR) begin
          pcSrc = 2'b11;
        end else begin
          pcSrc = 2'b10;
          if (instr_op_i == OP_JAL) begin
            regWrite = 1'b1;
            regDst   = 2'b10;
            memToReg = 2'b10;
          end
        end
        stateNext = FETCH;
      end
      TRAP: begin
        stateNext = TRAP;
      end
      default: begin
        stateNext = TRAP;
      end
    endcase
  end

  // Gate with reset so nothing strobes while rst_i is held low.
  assign pc_write_o   = rst_i & pcWrite;
  assign ir_write_o   = rst_i & irWrite;
  assign iord_o       = rst_i & iord;
  assign mem_read_o   = rst_i & memRead;
  assign mem_write_o  = rst_i & memWrite;
  assign reg_write_o  = rst_i & regWrite;
  assign reg_dst_o    = rst_i ? regDst : 2'b00;
  assign mem_to_reg_o = rst_i ? memToReg : 2'b00;
  assign alu_src_a_o  = rst_i & aluSrcA;
  assign alu_src_b_o  = rst_i ? aluSrcB : 2'b00;
  assign alu_op_o     = rst_i ? aluOp : 3'b000;
  assign pc_src_o     = rst_i ? pcSrc : 2'b00;
  assign illegal_o    = illegalQ;
  assign state_o      = state;
  assign retired_o    = retired;

endmodule
